// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI3 slave that turns one read or write burst at a time into accesses on a
// single-port synchronous SRAM. Reads and writes that are pending together
// are granted in round-robin order.
//
// Ports
//   clk, resetn                  clock (rising edge), async active-low reset
//   ar* / arvalid / arready      read address channel (lock/cache/prot unused)
//   rid/rdata/rresp/rlast/rvalid read data channel, rready from master
//   aw* / awvalid / awready      write address channel (lock/cache/prot unused)
//   wid/wdata/wstrb/wlast/wvalid write data channel (wid unused), wready out
//   bid/bresp/bvalid, bready     write response channel
//   sram_en/we/addr/wdata        SRAM request (we == 0 means read)
//   sram_rdata                   SRAM read data, valid the cycle after a read
//                                and held until the next access
module axi_sram_slave #(
  parameter int SRAM_AW = 16
) (
  input  logic               clk,
  input  logic               resetn,
  // read address
  input  logic [3:0]         arid,
  input  logic [31:0]        araddr,
  input  logic [7:0]         arlen,
  input  logic [2:0]         arsize,
  input  logic [1:0]         arburst,
  input  logic [1:0]         arlock,
  input  logic [3:0]         arcache,
  input  logic [2:0]         arprot,
  input  logic               arvalid,
  output logic               arready,
  // read data
  output logic [3:0]         rid,
  output logic [31:0]        rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  // write address
  input  logic [3:0]         awid,
  input  logic [31:0]        awaddr,
  input  logic [7:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic [1:0]         awlock,
  input  logic [3:0]         awcache,
  input  logic [2:0]         awprot,
  input  logic               awvalid,
  output logic               awready,
  // write data
  input  logic [3:0]         wid,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  // write response
  output logic [3:0]         bid,
  output logic [1:0]         bresp,
  output logic               bvalid,
  input  logic               bready,
  // SRAM
  output logic               sram_en,
  output logic [3:0]         sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_RESP} state_e;

  state_e      state_q, state_d;
  logic        last_rd_q, last_rd_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [8:0]  beats_left_q, beats_left_d;
  logic        rvalid_q, rvalid_d;
  logic        rd_first_q, rd_first_d;
  logic        err_q, err_d;
  logic        active_q;

  logic [31:0] step;
  logic [31:0] next_addr;
  logic        rlast_w;
  logic        rd_issue;

  // Sideband fields that carry no meaning for a plain SRAM.
  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // Beat address: low two bits select the byte lane and are dropped, bits
  // above the SRAM size are dropped so bursts wrap modulo the SRAM depth.
  assign sram_addr = addr_q[SRAM_AW+1:2];

  // The SRAM holds its output until the next access, so rdata stays stable
  // for as long as a beat is stalled.
  assign rdata   = sram_rdata;
  assign rid     = id_q;
  assign bid     = id_q;
  assign rresp   = 2'b00;
  assign rvalid  = rvalid_q;
  assign rlast_w = rvalid_q && (beats_left_q == 9'd1);
  assign rlast   = rlast_w;

  // Address step: 1 << min(size, 2); WRAP is treated as INCR, FIXED holds.
  always_comb begin
    step = 32'd4;
    case (size_q)
      3'd0:    step = 32'd1;
      3'd1:    step = 32'd2;
      default: step = 32'd4;
    endcase
    next_addr = (burst_q == 2'b00) ? addr_q : addr_q + step;
  end

  // Next-state and channel outputs. Arbitration is only live in IDLE and
  // only once the block has been out of reset for a cycle, so ready never
  // shows while resetn is low.
  always_comb begin
    state_d      = state_q;
    last_rd_d    = last_rd_q;
    id_d         = id_q;
    addr_d       = addr_q;
    size_d       = size_q;
    burst_d      = burst_q;
    beats_left_d = beats_left_q;
    rvalid_d     = rvalid_q;
    rd_first_d   = rd_first_q;
    err_d        = err_q;
    arready      = 1'b0;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    bresp        = 2'b00;
    sram_en      = 1'b0;
    sram_we      = 4'b0000;
    sram_wdata   = 32'd0;
    rd_issue     = 1'b0;

    case (state_q)
      IDLE: begin
        if (active_q) begin
          arready = arvalid && (!awvalid || !last_rd_q);
          awready = awvalid && (!arvalid || last_rd_q);
        end
        if (arready) begin
          id_d         = arid;
          addr_d       = araddr;
          size_d       = arsize;
          burst_d      = arburst;
          beats_left_d = {1'b0, arlen} + 9'd1;
          last_rd_d    = 1'b1;
          rd_first_d   = 1'b1;
          state_d      = RD;
        end else if (awready) begin
          id_d         = awid;
          addr_d       = awaddr;
          size_d       = awsize;
          burst_d      = awburst;
          beats_left_d = {1'b0, awlen} + 9'd1;
          last_rd_d    = 1'b0;
          err_d        = 1'b0;
          state_d      = WR;
        end
      end

      RD: begin
        // A new SRAM read is launched on entry and whenever a non-final beat
        // is taken, giving one beat per cycle with rready held high.
        rd_issue = rd_first_q || (rvalid_q && rready && !rlast_w);
        if (rvalid_q && rready) begin
          beats_left_d = beats_left_q - 9'd1;
          if (rlast_w) begin
            rvalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
        if (rd_issue) begin
          sram_en    = 1'b1;
          addr_d     = next_addr;
          rd_first_d = 1'b0;
          rvalid_d   = 1'b1;
        end
      end

      WR: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_en      = 1'b1;
          sram_we      = wstrb;
          sram_wdata   = wdata;
          addr_d       = next_addr;
          beats_left_d = beats_left_q - 9'd1;
          // The beat counter ends the burst; wlast is only cross-checked.
          if (wlast != (beats_left_q == 9'd1)) begin
            err_d = 1'b1;
          end
          if (beats_left_q == 9'd1) begin
            state_d = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        bvalid = 1'b1;
        bresp  = err_q ? 2'b10 : 2'b00;
        if (bready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_rd_q    <= 1'b0;
      id_q         <= 4'd0;
      addr_q       <= 32'd0;
      size_q       <= 3'd0;
      burst_q      <= 2'b00;
      beats_left_q <= 9'd0;
      rvalid_q     <= 1'b0;
      rd_first_q   <= 1'b0;
      err_q        <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_rd_q    <= last_rd_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      beats_left_q <= beats_left_d;
      rvalid_q     <= rvalid_d;
      rd_first_q   <= rd_first_d;
      err_q        <= err_d;
      active_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Testbench for axi_sram_slave: directed AXI bursts against a behavioural
// single-port SRAM, with hand-computed expected values.
module tb_axi_sram_slave;

  localparam int SRAM_AW = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  axi_sram_slave #(.SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural synchronous SRAM: byte-masked write, registered read that
  // holds its output until the next access.
  logic [31:0] mem [0:(1<<SRAM_AW)-1];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we != 4'b0000) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] wData [8];
  logic [3:0]  wStrb [8];
  logic [31:0] rBeat [8];
  int          rCycle [8];
  int          rCnt;
  int          rLastIdx;
  int          arCycle;
  logic [3:0]  rIdSeen;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One write burst of len+1 beats from wData/wStrb; wlast is raised on
  // beat wlastBeat. Returns the B response.
  task automatic doWrite(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst,
                         input int wlastBeat, output logic [1:0] resp,
                         output logic [3:0] bidOut);
    int n;
    int lastW;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst;
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) checkOutput("aw_timeout", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    lastW = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wData[i]; wstrb = wStrb[i]; wlast = (i == wlastBeat);
      n = 0;
      @(negedge clk);
      while (!wready && n < 20) begin @(negedge clk); n++; end
      if (!wready) checkOutput("w_timeout", {31'd0, wready}, 32'd1);
      lastW = cycleCnt;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    checkOutput("b_latency", cycleCnt - lastW, 32'd1);
    resp = bresp;
    bidOut = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // One read burst; beats land in rBeat/rCycle. With randReady the master
  // throttles rready and every stalled cycle checks that rdata holds.
  task automatic doRead(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [1:0] burst,
                        input bit randReady);
    int n;
    bit stalled;
    bit done;
    logic [31:0] prevData;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) checkOutput("ar_timeout", {31'd0, arready}, 32'd1);
    arCycle = cycleCnt;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rCnt = 0; rLastIdx = -1; stalled = 1'b0; done = 1'b0; prevData = 32'd0;
    rready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (rvalid) begin
        if (stalled) checkOutput("r_stable", rdata, prevData);
        if (rready) begin
          if (rCnt < 8) begin rBeat[rCnt] = rdata; rCycle[rCnt] = cycleCnt; end
          if (rlast && rLastIdx < 0) rLastIdx = rCnt;
          rIdSeen = rid;
          rCnt++;
          stalled = 1'b0;
          if (rlast) done = 1'b1;
        end else begin
          stalled = 1'b1;
          prevData = rdata;
        end
      end
      @(posedge clk); #1;
      rready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (!done) checkOutput("r_timeout", {31'd0, done}, 32'd1);
    rready = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [1:0] resp;
    logic [3:0] bidOut;
    logic [3:0] grants;
    int g;
    int n;
    int cnt;

    // Reset with both address channels requesting.
    resetn = 1'b0;
    arid = 4'd1; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    arlock = 2'b00; arcache = 4'd0; arprot = 3'd0;
    awid = 4'd2; awaddr = 32'h40; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    awlock = 2'b00; awcache = 4'd0; awprot = 3'd0;
    wid = 4'd0; wdata = 32'h55; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arvalid = 1'b1; awvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arready", {31'd0, arready}, 32'd0);
    checkOutput("rst_awready", {31'd0, awready}, 32'd0);
    checkOutput("rst_rvalid",  {31'd0, rvalid},  32'd0);
    checkOutput("rst_wready",  {31'd0, wready},  32'd0);
    checkOutput("rst_bvalid",  {31'd0, bvalid},  32'd0);
    checkOutput("rst_sram_en", {31'd0, sram_en}, 32'd0);
    checkOutput("rst_sram_we", {28'd0, sram_we}, 32'd0);
    checkOutput("rst_rlast",   {31'd0, rlast},   32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Round-robin: with both requests held, grants go R, W, R, W.
    grants = 4'b0000; g = 0; n = 0;
    while (g < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (arvalid && arready) begin grants[3-g] = 1'b1; g++; end
      else if (awvalid && awready) begin grants[3-g] = 1'b0; g++; end
      if (g == 4) begin @(posedge clk); #1; arvalid = 1'b0; awvalid = 1'b0; end
    end
    checkOutput("arb_count", g, 32'd4);
    checkOutput("arb_grant0", {31'd0, grants[3]}, 32'd1);
    checkOutput("arb_grant1", {31'd0, grants[2]}, 32'd0);
    checkOutput("arb_grant2", {31'd0, grants[1]}, 32'd1);
    checkOutput("arb_grant3", {31'd0, grants[0]}, 32'd0);
    arvalid = 1'b0; awvalid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b0;

    // Single write then read.
    wData[0] = 32'hDEADBEEF; wStrb[0] = 4'hF;
    doWrite(4'd3, 32'h100, 8'd0, 2'b01, 0, resp, bidOut);
    checkOutput("single_bresp", {30'd0, resp}, 32'd0);
    checkOutput("single_bid", {28'd0, bidOut}, 32'd3);
    doRead(4'd5, 32'h100, 8'd0, 2'b01, 1'b0);
    checkOutput("single_rdata", rBeat[0], 32'hDEADBEEF);
    checkOutput("single_rlast_idx", rLastIdx, 32'd0);
    checkOutput("single_rid", {28'd0, rIdSeen}, 32'd5);
    checkOutput("single_latency", rCycle[0] - arCycle, 32'd2);

    // INCR 4-beat write and read, one beat per cycle.
    for (int k = 0; k < 4; k++) begin wData[k] = k + 1; wStrb[k] = 4'hF; end
    doWrite(4'd4, 32'h200, 8'd3, 2'b01, 3, resp, bidOut);
    checkOutput("incr_bresp", {30'd0, resp}, 32'd0);
    doRead(4'd6, 32'h200, 8'd3, 2'b01, 1'b0);
    checkOutput("incr_count", rCnt, 32'd4);
    checkOutput("incr_rlast_idx", rLastIdx, 32'd3);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("incr_beat%0d", k), rBeat[k], k + 1);
      checkOutput($sformatf("incr_cycle%0d", k), rCycle[k] - arCycle, k + 2);
    end

    // 8-beat read under random backpressure.
    for (int k = 0; k < 8; k++) begin wData[k] = 32'hA0 + k; wStrb[k] = 4'hF; end
    doWrite(4'd1, 32'h500, 8'd7, 2'b01, 7, resp, bidOut);
    doRead(4'd2, 32'h500, 8'd7, 2'b01, 1'b1);
    checkOutput("bp_count", rCnt, 32'd8);
    checkOutput("bp_rlast_idx", rLastIdx, 32'd7);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("bp_beat%0d", k), rBeat[k], 32'hA0 + k);
    end

    // Byte strobes over an all-ones word.
    wData[0] = 32'hFFFFFFFF; wStrb[0] = 4'hF;
    doWrite(4'd0, 32'h600, 8'd0, 2'b01, 0, resp, bidOut);
    wData[0] = 32'h12345678; wStrb[0] = 4'b0011;
    doWrite(4'd0, 32'h600, 8'd0, 2'b01, 0, resp, bidOut);
    doRead(4'd0, 32'h600, 8'd0, 2'b01, 1'b0);
    checkOutput("strb_rdata", rBeat[0], 32'hFFFF5678);

    // FIXED burst: every beat hits the same word.
    wData[0] = 32'h11; wData[1] = 32'h22; wData[2] = 32'h33;
    wStrb[0] = 4'hF; wStrb[1] = 4'hF; wStrb[2] = 4'hF;
    doWrite(4'd7, 32'h300, 8'd2, 2'b00, 2, resp, bidOut);
    checkOutput("fixed_bresp", {30'd0, resp}, 32'd0);
    doRead(4'd7, 32'h300, 8'd0, 2'b01, 1'b0);
    checkOutput("fixed_rdata", rBeat[0], 32'h33);

    // wlast on the wrong beat gives SLVERR; the next clean write is OKAY.
    wData[0] = 32'h1; wData[1] = 32'h2; wStrb[0] = 4'hF; wStrb[1] = 4'hF;
    doWrite(4'd9, 32'h320, 8'd1, 2'b01, 0, resp, bidOut);
    checkOutput("wlast_err_bresp", {30'd0, resp}, 32'd2);
    checkOutput("wlast_err_bid", {28'd0, bidOut}, 32'd9);
    doWrite(4'd10, 32'h330, 8'd0, 2'b01, 0, resp, bidOut);
    checkOutput("err_clear_bresp", {30'd0, resp}, 32'd0);

    // Reset asserted while beat 2 of an 8-beat read is on the bus.
    arid = 4'd2; araddr = 32'h500; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    cnt = 0; n = 0;
    while (cnt < 2 && n < 20) begin
      if (n > 0 || cnt > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      n++;
      if (rvalid && rready) cnt++;
    end
    checkOutput("mid_beats_seen", cnt, 32'd2);
    resetn = 1'b0; arvalid = 1'b1;
    #1;
    checkOutput("mid_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("mid_arready", {31'd0, arready}, 32'd0);
    checkOutput("mid_sram_en", {31'd0, sram_en}, 32'd0);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    doRead(4'd8, 32'h500, 8'd7, 2'b01, 1'b0);
    checkOutput("post_rst_count", rCnt, 32'd8);
    checkOutput("post_rst_rlast_idx", rLastIdx, 32'd7);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("post_rst_beat%0d", k), rBeat[k], 32'hA0 + k);
    end
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guards against a hung handshake that the bounded loops somehow miss.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
